// File: rtl/la_wb_master.sv
// la_wb_master: Wishbone classic initiator; cmd valid/ready in -> one bus cycle with ack timeout -> rsp valid/ready out, plus txn/err counters
module la_wb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_n;
  logic [7:0] tcnt;
  logic ack, tout;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  always_comb begin
    ack = state == BUS && wbm_ack_i;
    tout = state == BUS && !wbm_ack_i && tcnt == 8'(TIMEOUT - 1);
    state_n = (state == IDLE && cmd_valid) ? BUS :
              (ack || tout) ? RESP :
              (state == RESP && rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      tcnt <= '0;
      rsp_dat <= '0;
      rsp_err <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      txn_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o <= cmd_we;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
        wbm_sel_o <= cmd_sel;
        tcnt <= '0;
      end
      if (ack) begin
        rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
        rsp_err <= 1'b0;
        txn_count <= txn_count + 16'd1;
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
      end else if (tout) begin
        rsp_dat <= '0;
        rsp_err <= 1'b1;
        err_count <= err_count + {7'd0, err_count != 8'hFF};
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
      end else if (state == BUS) begin
        tcnt <= tcnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_la_wb_master.sv
// tb_la_wb_master: directed self-checking bench for la_wb_master
module tb_la_wb_master;
  logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i = 1'b0;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = '0;
  logic [3:0]  wbm_sel_o;
  logic [15:0] txn_count;
  logic [7:0]  err_count;
  int total = 0, bad = 0;
  always #5 wb_clk_i = ~wb_clk_i;
  la_wb_master #(.TIMEOUT(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .txn_count(txn_count), .err_count(err_count)
  );
  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                         output int stb_n, output int lat);
    int g;
    stb_n = 0;
    lat = 0;
    g = 0;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_before_cmd got %b exp 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && g < 300) begin
      g++;
      if (wbm_stb_o === 1'b1) begin
        stb_n++;
        total++;
        if ({wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {1'b1, we, adr, dat, sel}) begin
          bad++;
          $display("FAIL bus_fields got cyc=%b we=%b adr=%h dat=%h sel=%h exp 1 %b %h %h %h",
                   wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, we, adr, dat, sel);
        end
      end
      wbm_ack_i = ack_at != 0 && wbm_stb_o === 1'b1 && stb_n == ack_at;
      wbm_dat_i = rdat;
      tick();
      wbm_ack_i = 1'b0;
      lat++;
    end
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rsp_wait got rsp_valid=%b exp 1 within 300 cycles", rsp_valid); end
    total++;
    if ({wbm_cyc_o, wbm_stb_o, cmd_ready} !== 3'b000) begin
      bad++; $display("FAIL resp_bus_idle got cyc/stb/cmd_ready=%b%b%b exp 000", wbm_cyc_o, wbm_stb_o, cmd_ready);
    end
  endtask
  task automatic finish_rsp;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL rsp_release got cmd_ready/rsp_valid=%b%b exp 10", cmd_ready, rsp_valid);
    end
  endtask
  task automatic test_reset;
    wb_rst_i = 1'b1;
    tick();
    tick();
    wb_rst_i = 1'b0;
    total++;
    if ({cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b100000 ||
        rsp_dat !== 32'd0 || wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0 || wbm_sel_o !== 4'd0 ||
        txn_count !== 16'd0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b err=%b cyc=%b stb=%b we=%b rdat=%h adr=%h dat=%h sel=%h txn=%0d errc=%0d exp all 0 except rdy=1",
               cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_dat, wbm_adr_o, wbm_dat_o, wbm_sel_o, txn_count, err_count);
    end
  endtask
  task automatic test_write_zero_wait;
    int s, l;
    run_txn(1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF, 1, 32'h1111_2222, s, l);
    total++;
    if (s != 1 || l != 2) begin bad++; $display("FAIL write_timing got stb=%0d lat=%0d exp 1 2", s, l); end
    total++;
    if (rsp_dat !== 32'd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL write_rsp got dat=%h err=%b exp 0 0", rsp_dat, rsp_err); end
    total++;
    if (txn_count !== 16'd1 || err_count !== 8'd0) begin bad++; $display("FAIL write_counts got txn=%0d err=%0d exp 1 0", txn_count, err_count); end
    finish_rsp();
  endtask
  task automatic test_read_wait;
    int s, l;
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 4, 32'hDEAD_BEEF, s, l);
    total++;
    if (s != 4 || l != 5) begin bad++; $display("FAIL read_timing got stb=%0d lat=%0d exp 4 5", s, l); end
    total++;
    if (rsp_dat !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin bad++; $display("FAIL read_rsp got dat=%h err=%b exp deadbeef 0", rsp_dat, rsp_err); end
    total++;
    if (txn_count !== 16'd2) begin bad++; $display("FAIL read_txn got %0d exp 2", txn_count); end
    finish_rsp();
  endtask
  task automatic test_timeout;
    int s, l;
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 32'hCAFE_F00D, s, l);
    total++;
    if (s != 16 || l != 17) begin bad++; $display("FAIL timeout_timing got stb=%0d lat=%0d exp 16 17", s, l); end
    total++;
    if (rsp_dat !== 32'd0 || rsp_err !== 1'b1) begin bad++; $display("FAIL timeout_rsp got dat=%h err=%b exp 0 1", rsp_dat, rsp_err); end
    total++;
    if (txn_count !== 16'd2 || err_count !== 8'd1) begin bad++; $display("FAIL timeout_counts got txn=%0d err=%0d exp 2 1", txn_count, err_count); end
    finish_rsp();
  endtask
  task automatic test_ack_last;
    int s, l;
    run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 16, 32'h0BAD_CAFE, s, l);
    total++;
    if (s != 16 || l != 17) begin bad++; $display("FAIL acklast_timing got stb=%0d lat=%0d exp 16 17", s, l); end
    total++;
    if (rsp_dat !== 32'h0BAD_CAFE || rsp_err !== 1'b0) begin bad++; $display("FAIL acklast_rsp got dat=%h err=%b exp 0badcafe 0", rsp_dat, rsp_err); end
    total++;
    if (txn_count !== 16'd3 || err_count !== 8'd1) begin bad++; $display("FAIL acklast_counts got txn=%0d err=%0d exp 3 1", txn_count, err_count); end
    finish_rsp();
  endtask
  task automatic test_backpressure;
    int s, l;
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'h1234_5678, s, l);
    cmd_valid = 1'b1;
    cmd_adr = 32'h4000_0000;
    for (int i = 0; i < 10; i++) begin
      wbm_ack_i = i == 5;
      wbm_dat_i = 32'hFFFF_FFFF;
      tick();
      wbm_ack_i = 1'b0;
      total++;
      if ({rsp_valid, cmd_ready, wbm_cyc_o, wbm_stb_o, rsp_err} !== 5'b10000 || rsp_dat !== 32'h1234_5678 || txn_count !== 16'd4) begin
        bad++;
        $display("FAIL backpressure got vld=%b rdy=%b cyc=%b stb=%b err=%b dat=%h txn=%0d exp 1 0 0 0 0 12345678 4",
                 rsp_valid, cmd_ready, wbm_cyc_o, wbm_stb_o, rsp_err, rsp_dat, txn_count);
      end
    end
    cmd_valid = 1'b0;
    finish_rsp();
  endtask
  task automatic test_reset_mid;
    int s, l;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    total++;
    if (wbm_stb_o !== 1'b1) begin bad++; $display("FAIL midreset_stb got %b exp 1", wbm_stb_o); end
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    total++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready} !== 4'b0001 || txn_count !== 16'd0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL midreset_state got cyc=%b stb=%b vld=%b rdy=%b txn=%0d err=%0d exp 0 0 0 1 0 0",
               wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, txn_count, err_count);
    end
    run_txn(1'b1, 32'h3000_0024, 32'h5555_AAAA, 4'h5, 2, 32'h0, s, l);
    total++;
    if (s != 2 || l != 3 || rsp_dat !== 32'd0 || rsp_err !== 1'b0 || txn_count !== 16'd1) begin
      bad++; $display("FAIL after_reset got stb=%0d lat=%0d dat=%h err=%b txn=%0d exp 2 3 0 0 1", s, l, rsp_dat, rsp_err, txn_count);
    end
    finish_rsp();
  endtask
  task automatic test_err_saturate;
    int s, l;
    for (int i = 1; i <= 256; i++) begin
      run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 32'h7777_7777, s, l);
      finish_rsp();
      if (i == 255) begin
        total++;
        if (err_count !== 8'hFF) begin bad++; $display("FAIL err_reach_ff got %h exp ff", err_count); end
      end
    end
    total++;
    if (err_count !== 8'hFF || txn_count !== 16'd1) begin bad++; $display("FAIL err_saturate got err=%h txn=%0d exp ff 1", err_count, txn_count); end
  endtask
  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_ack_last();
    test_backpressure();
    test_reset_mid();
    test_err_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/la_wb_master.md
# la_wb_master

Wishbone classic-cycle initiator that drives the user project's Wishbone slave port from inside the user area. It accepts single-word read/write commands over a valid/ready command channel (sourced from logic-analyzer probes or a test sequencer), runs one bus cycle per command with a bounded ack timeout, and returns read data or error status over a valid/ready response channel. It is the initiator counterpart to the `wbs_*` slave interface of `tiny_user_project`, and provides on-chip bring-up and self-test access.

## Interface
Parameters:
- TIMEOUT, 16: max consecutive STB cycles without ACK before abort; legal range 2..255.

Ports:
- wb_clk_i  in  1  single clock; all logic rising-edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte lanes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when both high.
- rsp_dat  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout abort.
- wbm_cyc_o  out  1  Wishbone CYC.
- wbm_stb_o  out  1  Wishbone STB.
- wbm_we_o  out  1  Wishbone WE.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_sel_o  out  4  Wishbone SEL.
- wbm_ack_i  in  1  Wishbone ACK.
- wbm_dat_i  in  32  Wishbone read data.
- txn_count  out  16  completed (acked) transactions, wraps 0xFFFF->0.
- err_count  out  8  timeout aborts, saturates at 0xFF.

## Operation
- States: IDLE, BUS, RESP. Reset -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid: register cmd_we/adr/dat/sel into wbm_* outputs, clear timeout counter, -> BUS.
- BUS: wbm_cyc_o=wbm_stb_o=1; wbm_we/adr/dat/sel held stable for the whole cycle.
  - wbm_ack_i=1: capture wbm_dat_i into rsp_dat if read (0 if write), rsp_err=0, txn_count+1, drop CYC/STB, -> RESP.
  - No ACK, timeout counter == TIMEOUT-1: rsp_dat=0, rsp_err=1, err_count+1 (saturating), drop CYC/STB, -> RESP.
  - Otherwise timeout counter +1 (8-bit).
  - ACK and timeout on the same edge: ACK wins (normal completion).
- RESP: rsp_valid=1, rsp_dat/rsp_err stable. On rsp_ready -> IDLE.
- One outstanding transaction; cmd_ready=0 in BUS and RESP.
- wbm_ack_i outside BUS ignored; no counter change.
- wbm_dat_o/wbm_sel_o/wbm_we_o/wbm_adr_o keep last values outside BUS (don't-care to slave, but must not glitch during BUS).

## Timing
- All outputs registered except cmd_ready and rsp_valid (decoded from state register only, no input paths).
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_dat=0, rsp_err=0, all wbm_* outputs 0, txn_count=0, err_count=0.
- Command accepted at edge E0 -> CYC/STB high in cycle after E0.
- ACK sampled high at edge En -> CYC/STB low and rsp_valid high in the cycle after En. Zero-wait slave (ACK in first STB cycle): command-to-rsp_valid = 2 cycles.
- rsp_ready high while rsp_valid -> cmd_ready high next cycle; back-to-back throughput = 1 transaction per 3 cycles minimum.
- Timeout: STB high for exactly TIMEOUT cycles, then low.
- wb_rst_i mid-transaction: at the reset edge all state returns to reset values; CYC/STB low next cycle; pending response discarded; no counter increment.

## Test plan
- Write, zero-wait slave: cmd_we=1, adr=0x3000_0000, dat=0xA5A5_1234, sel=0xF -> single cycle STB with those values; rsp_valid 2 cycles after accept, rsp_dat=0, rsp_err=0, txn_count=1.
- Read, 3 wait states: cmd_we=0, adr=0x3000_0004, slave ACKs on 4th STB cycle with 0xDEAD_BEEF -> STB high 4 cycles, rsp_dat=0xDEAD_BEEF, rsp_err=0.
- Timeout, TIMEOUT=16, slave never ACKs -> STB high exactly 16 cycles, rsp_err=1, rsp_dat=0, err_count=1, txn_count unchanged; 256 timeouts -> err_count stays 0xFF.
- ACK on final timeout cycle (16th) -> rsp_err=0, txn_count+1, err_count unchanged.
- Response backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_dat stable, cmd_ready=0, no new CYC; stray ACK during RESP ignored.
- Reset in BUS cycle 2 of a read -> CYC/STB low next cycle, rsp_valid=0, counters 0, next command executes normally.
